// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory-access stage: LSU funct3 codes,
// FSM encoding and the latched in-flight op.
package mem_access_unit_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic {
    MA_IDLE = 1'b0,
    MA_WAIT = 1'b1
  } ma_state_e;

  // Everything needed to finish an op once the memory answers.
  typedef struct packed {
    logic        load;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] addr;
  } mem_op_t;

  // Unsigned variants exist only for loads.
  function automatic logic lsu_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    ok = 1'b0;
    case (f3)
      LSU_B, LSU_H, LSU_W: ok = 1'b1;
      LSU_BU, LSU_HU:      ok = ~is_store;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational data alignment: store lane replication/byte mask, load lane
// extraction with sign/zero extension, and the misaligned/illegal check.
module mem_align_unit
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic        is_store_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wmask_o,
  output logic        fault_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic       misal;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    misal = 1'b0;
    case (funct3_i[1:0])
      2'b01:   misal = off_i[0];
      2'b10:   misal = (off_i != 2'b00);
      default: misal = 1'b0;
    endcase
  end

  assign fault_o = misal | ~lsu_legal(funct3_i, is_store_i);

  always_comb begin
    wdata_o = rs2_i;
    wmask_o = 4'b1111;
    case (funct3_i[1:0])
      2'b00: begin
        wdata_o = {4{rs2_i[7:0]}};
        wmask_o = 4'b0001 << off_i;
      end
      2'b01: begin
        wdata_o = {2{rs2_i[15:0]}};
        wmask_o = off_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_o = rs2_i;
        wmask_o = 4'b1111;
      end
    endcase
  end

  always_comb begin
    case (ld_off_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (ld_funct3_i)
      LSU_B:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      LSU_BU:  ld_data_o = {24'd0, ld_byte};
      LSU_H:   ld_data_o = {{16{ld_half[15]}}, ld_half};
      LSU_HU:  ld_data_o = {16'd0, ld_half};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage after the ALU: passes non-memory results through, runs aligned
// loads/stores over a req/ack port, and converts unanswered requests to bus errors.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_misal,
  output logic        bus_err,
  output logic [31:0] exc_addr
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  // Expiry is detected on the last counted cycle so req is high exactly TIMEOUT_CYCLES cycles.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 32'd0);

  ma_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_op_t          op_q, op_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic             kill_q, kill_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             misal_q, misal_d;
  logic             berr_q, berr_d;
  logic [31:0]      exc_addr_q, exc_addr_d;

  logic        accept, is_mem, expire;
  logic [31:0] fmt_wdata, ld_data;
  logic [3:0]  fmt_wmask;
  logic        fmt_fault;

  mem_align_unit u_align (
    .funct3_i    (ex_funct3),
    .off_i       (ex_result[1:0]),
    .is_store_i  (ex_store),
    .rs2_i       (ex_rs2),
    .wdata_o     (fmt_wdata),
    .wmask_o     (fmt_wmask),
    .fault_o     (fmt_fault),
    .ld_funct3_i (op_q.funct3),
    .ld_off_i    (op_q.addr[1:0]),
    .rdata_i     (dmem_rdata),
    .ld_data_o   (ld_data)
  );

  assign ex_ready = (state_q == MA_IDLE) & ~flush & ~reset;
  assign accept   = ex_valid & ex_ready;
  assign is_mem   = ex_load | ex_store;
  assign expire   = TO_EN && (cnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    req_d      = req_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    kill_d     = kill_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    misal_d    = 1'b0;
    berr_d     = 1'b0;
    exc_addr_d = exc_addr_q;
    case (state_q)
      MA_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_result;
          end else if (fmt_fault) begin
            misal_d    = 1'b1;
            exc_addr_d = ex_result;
          end else begin
            state_d = MA_WAIT;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = ex_store;
            wdata_d = fmt_wdata;
            wmask_d = ex_store ? fmt_wmask : 4'b0000;
            kill_d  = 1'b0;
            op_d    = '{load: ex_load, funct3: ex_funct3, rd: ex_rd, addr: ex_result};
          end
        end
      end
      MA_WAIT: begin
        // A flush lets the bus transaction finish but forgets its result.
        if (flush) kill_d = 1'b1;
        if (dmem_ack) begin
          state_d = MA_IDLE;
          req_d   = 1'b0;
          if (op_q.load && !kill_q && !flush) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = op_q.rd;
            wb_data_d  = ld_data;
          end
        end else if (expire) begin
          state_d    = MA_IDLE;
          req_d      = 1'b0;
          berr_d     = 1'b1;
          exc_addr_d = op_q.addr;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MA_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      kill_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misal_q    <= 1'b0;
      berr_q     <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      req_q      <= req_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      kill_q     <= kill_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      misal_q    <= misal_d;
      berr_q     <= berr_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = {op_q.addr[31:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_wmask = wmask_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign exc_misal  = misal_q;
  assign bus_err    = berr_q;
  assign exc_addr   = exc_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scenario bench for mem_access_unit: expected writebacks are queued when an op
// is driven and popped when wb_valid appears.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_result, ex_rs2;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wmask;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_misal, bus_err;
  logic [31:0] exc_addr;

  int n_chk = 0;
  int n_fail = 0;
  logic [36:0] exp_q[$];
  logic [36:0] exp_wb;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_load(ex_load), .ex_store(ex_store), .ex_funct3(ex_funct3),
    .ex_result(ex_result), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .exc_misal(exc_misal), .bus_err(bus_err),
    .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_valid = 0; ex_load = 0; ex_store = 0; ex_funct3 = 3'b000;
    ex_result = 0; ex_rs2 = 0; ex_rd = 0; flush = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] rs2, input logic [4:0] rd);
    ex_valid = 1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_result = a; ex_rs2 = rs2; ex_rd = rd;
  endtask

  task automatic test_reset();
    idle_in();
    reset = 1;
    tick(); tick();
    n_chk++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ex_ready); end
    n_chk++; if ({dmem_req, wb_valid, exc_misal, bus_err} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 0000", {dmem_req, wb_valid, exc_misal, bus_err}); end
    n_chk++; if ({wb_data, exc_addr, dmem_addr} !== 96'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {wb_data, exc_addr, dmem_addr}); end
    reset = 0;
    #1;
    n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b want 1", ex_ready); end
  endtask

  task automatic test_alu_pass();
    issue(0, 0, 3'b000, 32'h1234, 32'h0, 5'd5);
    exp_q.push_back({5'd5, 32'h1234});
    tick();
    idle_in();
    n_chk++;
    if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_wb_valid: got %b want 1", wb_valid); end
    else begin
      exp_wb = exp_q.pop_front();
      if ({wb_rd, wb_data} !== exp_wb) begin n_fail++; $display("FAIL alu_wb: got %h want %h", {wb_rd, wb_data}, exp_wb); end
    end
    tick();
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_pulse: got %b want 0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = $urandom;
      issue(0, 0, 3'b010, v, 32'h0, 5'(i + 10));
      exp_q.push_back({5'(i + 10), v});
      tick();
      n_chk++;
      if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid%0d: got %b want 1", i, wb_valid); end
      else begin
        exp_wb = exp_q.pop_front();
        if ({wb_rd, wb_data} !== exp_wb) begin n_fail++; $display("FAIL b2b_wb%0d: got %h want %h", i, {wb_rd, wb_data}, exp_wb); end
      end
    end
    idle_in();
    tick();
  endtask

  task automatic test_store();
    logic [31:0] a_t[3], rs_t[3], wd_t[3];
    logic [2:0]  f_t[3];
    logic [3:0]  m_t[3];
    a_t = '{32'h103, 32'h202, 32'h304};
    f_t = '{3'b000, 3'b001, 3'b010};
    rs_t = '{32'h000000AB, 32'h1234BEEF, 32'hCAFEF00D};
    wd_t = '{32'hABABABAB, 32'hBEEFBEEF, 32'hCAFEF00D};
    m_t = '{4'b1000, 4'b1100, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      issue(0, 1, f_t[i], a_t[i], rs_t[i], 5'd3);
      tick();
      idle_in();
      for (int w = 0; w < i; w++) tick();
      n_chk++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask} !== {2'b11, a_t[i] & 32'hFFFFFFFC, wd_t[i], m_t[i]})
        begin n_fail++; $display("FAIL st%0d_bus: got %b %b %h %h %b want 1 1 %h %h %b", i, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask, a_t[i] & 32'hFFFFFFFC, wd_t[i], m_t[i]); end
      dmem_ack = 1;
      tick();
      dmem_ack = 0;
      n_chk++; if ({dmem_req, wb_valid} !== 2'b00) begin n_fail++; $display("FAIL st%0d_done: got req=%b wb=%b want 0 0", i, dmem_req, wb_valid); end
      n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL st%0d_ready: got %b want 1", i, ex_ready); end
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] rdata;
    logic [31:0] res;
    int          dly;
  } ld_t;

  task automatic test_loads();
    ld_t t[6];
    t[0] = '{3'b000, 32'h102, 32'h00800000, 32'hFFFFFF80, 0};
    t[1] = '{3'b100, 32'h102, 32'h00800000, 32'h00000080, 1};
    t[2] = '{3'b001, 32'h002, 32'h80010000, 32'hFFFF8001, 0};
    t[3] = '{3'b101, 32'h002, 32'h80010000, 32'h00008001, 2};
    t[4] = '{3'b010, 32'h008, 32'hDEADBEEF, 32'hDEADBEEF, 0};
    t[5] = '{3'b000, 32'h101, 32'h00007F00, 32'h0000007F, 1};
    for (int i = 0; i < 6; i++) begin
      issue(1, 0, t[i].f3, t[i].a, 32'h0, 5'(i + 1));
      exp_q.push_back({5'(i + 1), t[i].res});
      tick();
      idle_in();
      for (int w = 0; w < t[i].dly; w++) tick();
      n_chk++;
      if ({dmem_req, dmem_we, dmem_addr} !== {2'b10, t[i].a & 32'hFFFFFFFC}) begin n_fail++; $display("FAIL ld%0d_req: got %b %b %h want 1 0 %h", i, dmem_req, dmem_we, dmem_addr, t[i].a & 32'hFFFFFFFC); end
      dmem_ack = 1; dmem_rdata = t[i].rdata;
      tick();
      dmem_ack = 0; dmem_rdata = 0;
      n_chk++;
      if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL ld%0d_wb_valid: got %b want 1", i, wb_valid); end
      else begin
        exp_wb = exp_q.pop_front();
        if ({wb_rd, wb_data} !== exp_wb) begin n_fail++; $display("FAIL ld%0d_wb: got %h want %h", i, {wb_rd, wb_data}, exp_wb); end
      end
    end
    tick();
  endtask

  task automatic test_misaligned();
    logic       ld_t_[4], st_t_[4];
    logic [2:0] f_t[4];
    logic [31:0] a_t[4];
    ld_t_ = '{1'b1, 1'b1, 1'b0, 1'b1};
    st_t_ = '{1'b0, 1'b0, 1'b1, 1'b0};
    f_t = '{3'b010, 3'b001, 3'b100, 3'b011};
    a_t = '{32'h6, 32'h201, 32'h300, 32'h400};
    for (int i = 0; i < 4; i++) begin
      issue(ld_t_[i], st_t_[i], f_t[i], a_t[i], 32'h55, 5'd7);
      tick();
      idle_in();
      n_chk++;
      if ({exc_misal, exc_addr} !== {1'b1, a_t[i]}) begin n_fail++; $display("FAIL mis%0d_exc: got %b %h want 1 %h", i, exc_misal, exc_addr, a_t[i]); end
      n_chk++;
      if ({dmem_req, wb_valid, ex_ready} !== 3'b001) begin n_fail++; $display("FAIL mis%0d_state: got req/wb/rdy %b want 001", i, {dmem_req, wb_valid, ex_ready}); end
      tick();
      n_chk++; if (exc_misal !== 1'b0) begin n_fail++; $display("FAIL mis%0d_pulse: got %b want 0", i, exc_misal); end
    end
  endtask

  task automatic test_timeout();
    int n;
    issue(1, 0, 3'b010, 32'h40, 32'h0, 5'd9);
    tick();
    idle_in();
    n = 0;
    while (dmem_req && n < 20) begin
      n++;
      n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_early_err: got %b want 0 at req cycle %0d", bus_err, n); end
      tick();
    end
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 4", n); end
    n_chk++; if ({bus_err, exc_addr, wb_valid} !== {1'b1, 32'h40, 1'b0}) begin n_fail++; $display("FAIL to_err: got %b %h wb=%b want 1 00000040 0", bus_err, exc_addr, wb_valid); end
    n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready: got %b want 1", ex_ready); end
    tick();
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got %b want 0", bus_err); end
    // answer on the last allowed cycle: ack must win over expiry
    issue(1, 0, 3'b010, 32'h44, 32'h0, 5'd11);
    exp_q.push_back({5'd11, 32'h0BADF00D});
    tick();
    idle_in();
    tick(); tick(); tick();
    dmem_ack = 1; dmem_rdata = 32'h0BADF00D;
    tick();
    dmem_ack = 0;
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_ack_wins_err: got %b want 0", bus_err); end
    n_chk++;
    if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL to_ack_wins_wb: got %b want 1", wb_valid); end
    else begin
      exp_wb = exp_q.pop_front();
      if ({wb_rd, wb_data} !== exp_wb) begin n_fail++; $display("FAIL to_ack_wb: got %h want %h", {wb_rd, wb_data}, exp_wb); end
    end
    tick();
  endtask

  task automatic test_flush();
    issue(1, 0, 3'b010, 32'h80, 32'h0, 5'd12);
    tick();
    idle_in();
    flush = 1;
    tick();
    flush = 0;
    n_chk++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL fl_req_held: got %b want 1", dmem_req); end
    tick(); tick();
    dmem_ack = 1; dmem_rdata = 32'h12345678;
    tick();
    dmem_ack = 0;
    n_chk++; if ({dmem_req, wb_valid} !== 2'b00) begin n_fail++; $display("FAIL fl_no_wb: got req=%b wb=%b want 0 0", dmem_req, wb_valid); end
    // flush only in the ack cycle
    issue(1, 0, 3'b010, 32'h84, 32'h0, 5'd13);
    tick();
    idle_in();
    dmem_ack = 1; flush = 1;
    tick();
    idle_in();
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL fl_ack_cycle: got %b want 0", wb_valid); end
    // flush in IDLE blocks acceptance
    flush = 1;
    issue(0, 0, 3'b000, 32'h99, 32'h0, 5'd14);
    #1;
    n_chk++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready: got %b want 0", ex_ready); end
    tick();
    idle_in();
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL fl_idle_accept: got %b want 0", wb_valid); end
  endtask

  task automatic test_reset_mid();
    issue(1, 0, 3'b010, 32'hC0, 32'h0, 5'd15);
    tick();
    idle_in();
    reset = 1;
    tick();
    n_chk++; if ({dmem_req, wb_valid, exc_misal, bus_err} !== 4'b0) begin n_fail++; $display("FAIL rst_mid: got %b want 0000", {dmem_req, wb_valid, exc_misal, bus_err}); end
    reset = 0;
    dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
    tick();
    dmem_ack = 0;
    n_chk++; if ({dmem_req, wb_valid, ex_ready} !== 3'b001) begin n_fail++; $display("FAIL rst_stray_ack: got req/wb/rdy %b want 001", {dmem_req, wb_valid, ex_ready}); end
    n_chk++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1;
    idle_in();
    test_reset();
    test_alu_pass();
    test_back_to_back();
    test_store();
    test_loads();
    test_misaligned();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
